// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and default constants for the FIFO write arbiter
//
// Purpose : arbiter state encoding and default parameter values.
// Ports   : none (package).
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int ARB_WIDTH = 16;
    localparam int ARB_NREQ  = 4;
    localparam int ARB_BURST = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin picker
//
// Purpose : selects the first set request bit at or after start_i, wrapping modulo NREQ.
// Ports   : req_i   - request vector
//           start_i - index searched first
//           grant_o - one-hot winner (zero when no request)
//           idx_o   - binary index of the winner (zero when no request)
//           valid_o - high when any request bit is set
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = ARB_NREQ,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   start_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            valid_o
);

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = int'(start_i) + i;
            if (k >= NREQ) begin
                k = k - NREQ;
            end
            if (!valid_o && req_i[k]) begin
                valid_o    = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = IW'(k);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter feeding one FIFO write port
//
// Purpose : grants one requester at a time for up to BURST accepted beats, then
//           rotates round-robin; full_i stalls the current burst.
// Ports   : clk_i      - clock
//           rst_n_i    - asynchronous active-low reset
//           req_i      - per-requester write request
//           wdata_i    - packed requester data, slice k = [k*WIDTH +: WIDTH]
//           full_i     - FIFO full flag
//           grant_o    - registered one-hot grant (zero when idle)
//           grant_id_o - registered index of the granted requester (zero when idle)
//           wr_en_o    - FIFO write enable
//           wdata_o    - FIFO write data (zero when idle)
//           busy_o     - high while a grant is held
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH = ARB_WIDTH,
    parameter int NREQ  = ARB_NREQ,
    parameter int BURST = ARB_BURST
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] wdata_i,
    input  logic                  full_i,
    output logic [NREQ-1:0]       grant_o,
    output logic [2:0]            grant_id_o,
    output logic                  wr_en_o,
    output logic [WIDTH-1:0]      wdata_o,
    output logic                  busy_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BURST) + 1;

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   gid_q, gid_d;
    logic [IW-1:0]   last_q, last_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            accept;
    logic [IW-1:0]   start_idx;
    logic [NREQ-1:0] others;
    logic [NREQ-1:0] pick_req;
    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic [CW-1:0]   cnt_inc;
    logic            release_grant;

    // Grant is zero in IDLE, so accept can only fire for the granted requester.
    assign accept = (|(grant_q & req_i)) && !full_i;

    // In BURST last_q equals gid_q, so one start index serves both states.
    assign start_idx = (last_q == IW'(NREQ - 1)) ? '0 : last_q + IW'(1);

    // The releasing requester competes again only when nobody else is asking,
    // which gives a sole requester back-to-back grants.
    assign others   = req_i & ~grant_q;
    assign pick_req = (state_q == fifo_arb_pkg::IDLE) ? req_i
                    : ((|others) ? others : req_i);

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .req_i   (pick_req),
        .start_i (start_idx),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign cnt_inc       = cnt_q + CW'(accept);
    assign release_grant = (accept && (cnt_inc == CW'(BURST))) || !req_i[gid_q];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gid_d   = gid_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            fifo_arb_pkg::IDLE: begin
                if (pick_valid) begin
                    state_d = fifo_arb_pkg::BURST;
                    grant_d = pick_grant;
                    gid_d   = pick_idx;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                end
            end
            fifo_arb_pkg::BURST: begin
                if (release_grant) begin
                    if (pick_valid) begin
                        grant_d = pick_grant;
                        gid_d   = pick_idx;
                        last_d  = pick_idx;
                        cnt_d   = '0;
                    end else begin
                        state_d = fifo_arb_pkg::IDLE;
                        grant_d = '0;
                        gid_d   = '0;
                        cnt_d   = '0;
                    end
                end else begin
                    // Frozen while full_i is high because accept is low.
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = fifo_arb_pkg::IDLE;
                grant_d = '0;
                gid_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= fifo_arb_pkg::IDLE;
            grant_q <= '0;
            gid_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant_o    = grant_q;
    assign grant_id_o = 3'(gid_q);
    assign busy_o     = (state_q == fifo_arb_pkg::BURST);
    assign wr_en_o    = accept;
    assign wdata_o    = busy_o ? wdata_i[int'(gid_q)*WIDTH +: WIDTH] : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int W = 16;
    localparam int N = 4;
    localparam int B = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic           full;
    logic [N-1:0]   grant;
    logic [2:0]     grant_id;
    logic           wr_en;
    logic [W-1:0]   wdata_out;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;
    int exp_beats [N];
    int obs_beats [N];

    fifo_wr_arbiter #(
        .WIDTH (W),
        .NREQ  (N),
        .BURST (B)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .req_i      (req),
        .wdata_i    (wdata),
        .full_i     (full),
        .grant_o    (grant),
        .grant_id_o (grant_id),
        .wr_en_o    (wr_en),
        .wdata_o    (wdata_out),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs mid-cycle against the expected grant
    // (gid < 0 means idle) and write enable, then advance past the next edge.
    task automatic cyc(input int gid, input bit en);
        logic [31:0] eg, eid, ed;
        int idx;
        eg  = (gid >= 0) ? (32'd1 << gid) : 32'd0;
        eid = (gid >= 0) ? 32'(gid) : 32'd0;
        ed  = (gid >= 0) ? (32'h0000_A000 + 32'(gid)) : 32'd0;
        @(negedge clk);
        chk("grant",    32'(grant),     eg);
        chk("grant_id", 32'(grant_id),  eid);
        chk("busy",     32'(busy),      32'(gid >= 0));
        chk("wr_en",    32'(wr_en),     32'(en));
        chk("wdata",    32'(wdata_out), ed);
        if (en && gid >= 0) exp_beats[gid]++;
        if (wr_en) begin
            idx = int'(wdata_out) - 32'hA000;
            if (idx >= 0 && idx < N) obs_beats[idx]++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            wdata[k*W +: W] = 16'hA000 + 16'(k);
            exp_beats[k] = 0;
            obs_beats[k] = 0;
        end
        rst_n = 1'b0;
        req   = 4'b1111;
        full  = 1'b0;

        // Reset state with every requester asking.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant),     32'd0);
        chk("rst_gid",   32'(grant_id),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_wr_en", 32'(wr_en),     32'd0);
        chk("rst_wdata", 32'(wdata_out), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round-robin 0,1,2,3,0 with four beats each and no gaps.
        cyc(-1, 1'b0);
        for (int s = 0; s < 5; s++) begin
            for (int b = 0; b < B; b++) cyc(s % N, 1'b1);
        end
        cyc(1, 1'b1);
        cyc(1, 1'b1);

        // Reset mid-burst takes effect without a clock edge.
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_busy",  32'(busy),  32'd0);
        chk("mid_rst_gid",   32'(grant_id), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(-1, 1'b0);
        cyc(0, 1'b1);
        req = 4'b0000;
        cyc(0, 1'b0);
        cyc(-1, 1'b0);

        // Early drop: requester 2 leaves after two beats, 3 takes over with a fresh count.
        req = 4'b1100;
        cyc(-1, 1'b0);
        cyc(2, 1'b1);
        cyc(2, 1'b1);
        req = 4'b1000;
        cyc(2, 1'b0);
        for (int b = 0; b < B; b++) cyc(3, 1'b1);
        req = 4'b0000;
        cyc(3, 1'b0);
        cyc(-1, 1'b0);

        // Full stall after beat 1 of requester 1.
        req = 4'b0010;
        cyc(-1, 1'b0);
        cyc(1, 1'b1);
        full = 1'b1;
        for (int c = 0; c < 5; c++) cyc(1, 1'b0);
        full = 1'b0;
        for (int b = 0; b < 3; b++) cyc(1, 1'b1);
        req = 4'b0000;
        cyc(1, 1'b0);
        cyc(-1, 1'b0);

        // Sole requester 0 for ten beats: regranted with no idle cycle.
        req = 4'b0001;
        cyc(-1, 1'b0);
        for (int b = 0; b < 10; b++) cyc(0, 1'b1);
        req = 4'b0000;
        cyc(0, 1'b0);
        cyc(-1, 1'b0);

        // Scoreboard: every expected beat arrived once with the right data.
        for (int k = 0; k < N; k++) begin
            chk($sformatf("sb_beats_%0d", k), 32'(obs_beats[k]), 32'(exp_beats[k]));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
